// File: rtl/booth_pkg.sv
// Shared widths, FSM state type and Booth digit-window extraction for the
// radix-16 multiplier accumulator.
package booth_pkg;

  localparam int MUL_W   = 8;
  localparam int PP_W    = 12;
  localparam int PROD_W  = 2 * MUL_W;
  localparam int NUM_DIG = MUL_W / 4;
  localparam int CNT_W   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Window {y[4i+3:4i], y[4i-1]} with the implicit y[-1] = 0 appended.
  function automatic logic [4:0] digit_win(input logic [MUL_W-1:0] y,
                                           input logic [CNT_W-1:0] idx);
    logic [MUL_W:0] yx;
    yx = {y, 1'b0};
    return yx[{idx, 2'b00} +: 5];
  endfunction

endpackage

// File: rtl/booth_r16_sel.sv
// Radix-16 Booth digit decode and multiple selection; produces one signed
// 12-bit partial product from a 5-bit digit window.
module booth_r16_sel
  import booth_pkg::*;
(
  input  logic        [4:0]      win,
  input  logic signed [7:0]      x1,
  input  logic signed [9:0]      x3,
  input  logic signed [10:0]     x5,
  input  logic signed [10:0]     x7,
  output logic signed [PP_W-1:0] pp
);

  logic signed [4:0]      d;
  logic                   neg;
  logic        [3:0]      mag;
  logic signed [PP_W-1:0] x1e, x3e, x5e, x7e, sel;

  always_comb begin
    x1e = {{(PP_W-8){x1[7]}}, x1};
    x3e = {{(PP_W-10){x3[9]}}, x3};
    x5e = {{(PP_W-11){x5[10]}}, x5};
    x7e = {{(PP_W-11){x7[10]}}, x7};
    // -8*w4 + 4*w3 + 2*w2 + w1 is the signed nibble w[4:1]; w0 adds one more
    d   = $signed({w4_ext(win), win[4:1]}) + $signed({4'b0000, win[0]});
    neg = d[4];
    mag = neg ? 4'(-d) : d[3:0];
    case (mag)
      4'd1:    sel = x1e;
      4'd2:    sel = x1e <<< 1;
      4'd3:    sel = x3e;
      4'd4:    sel = x1e <<< 2;
      4'd5:    sel = x5e;
      4'd6:    sel = x3e <<< 1;
      4'd7:    sel = x7e;
      4'd8:    sel = x1e <<< 3;
      default: sel = '0;
    endcase
    pp = neg ? -sel : sel;
  end

  function automatic logic w4_ext(input logic [4:0] w);
    return w[4];
  endfunction

endmodule

// File: rtl/en_reg.sv
// Enable register with synchronous active-high clear.
module en_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/booth_r16_accum.sv
// Radix-16 Booth 8x8 signed multiplier: captures precomputed multiples and
// accumulates one partial product per cycle, pulsing oValid with the result.
module booth_r16_accum #(
  parameter int MUL_W   = 8,
  parameter int NUM_DIG = MUL_W / 4,
  parameter int PROD_W  = 2 * MUL_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iStart,
  input  logic signed [MUL_W-1:0]  iMul,
  input  logic signed [MUL_W-1:0]  iDat1X,
  input  logic signed [MUL_W+1:0]  iDat3X,
  input  logic signed [MUL_W+2:0]  iDat5X,
  input  logic signed [MUL_W+2:0]  iDat7X,
  output logic                     oBusy,
  output logic                     oValid,
  output logic signed [PROD_W-1:0] oProd
);

  import booth_pkg::state_t;
  import booth_pkg::IDLE;
  import booth_pkg::CALC;
  import booth_pkg::DONE;
  import booth_pkg::PP_W;
  import booth_pkg::CNT_W;
  import booth_pkg::digit_win;

  if (MUL_W != 8 || NUM_DIG != 2 || PROD_W != 16) begin : g_bad_width
    $error("booth_r16_accum supports only MUL_W=8 (NUM_DIG=2, PROD_W=16)");
  end

  localparam int CAP_W = 5 * MUL_W + 8;

  state_t                   state;
  logic       [CNT_W-1:0]   cnt_p1;
  logic signed [PROD_W-1:0] acc_p1;
  logic                     accept;
  logic       [CAP_W-1:0]   cap_p0;
  logic signed [MUL_W-1:0]  mul_p0, x1_p0;
  logic signed [MUL_W+1:0]  x3_p0;
  logic signed [MUL_W+2:0]  x5_p0, x7_p0;
  logic       [4:0]         win;
  logic signed [PP_W-1:0]   pp;
  logic signed [PROD_W-1:0] pp_ext, pp_sh, sum;

  assign accept = iStart && (state != CALC);

  // Stage p0: operand capture on accept
  en_reg #(.W(CAP_W)) u_cap (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .d   ({iMul, iDat1X, iDat3X, iDat5X, iDat7X}),
    .q   (cap_p0)
  );

  assign {mul_p0, x1_p0, x3_p0, x5_p0, x7_p0} = cap_p0;

  assign win = digit_win(mul_p0, cnt_p1);

  booth_r16_sel u_sel (
    .win (win),
    .x1  (x1_p0),
    .x3  (x3_p0),
    .x5  (x5_p0),
    .x7  (x7_p0),
    .pp  (pp)
  );

  always_comb begin
    pp_ext = {{(PROD_W-PP_W){pp[PP_W-1]}}, pp};
    pp_sh  = pp_ext <<< {cnt_p1, 2'b00};
    sum    = acc_p1 + pp_sh;
  end

  // Stage p1: digit accumulation and result hand-off
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt_p1 <= '0;
      acc_p1 <= '0;
      oProd  <= '0;
      oValid <= 1'b0;
      oBusy  <= 1'b0;
    end else begin
      oValid <= 1'b0;
      case (state)
        CALC: begin
          acc_p1 <= sum;
          cnt_p1 <= cnt_p1 + 1'b1;
          if (cnt_p1 == CNT_W'(NUM_DIG - 1)) begin
            state  <= DONE;
            oBusy  <= 1'b0;
            oValid <= 1'b1;
            oProd  <= sum;
          end
        end
        default: begin
          if (iStart) begin
            state  <= CALC;
            cnt_p1 <= '0;
            acc_p1 <= '0;
            oBusy  <= 1'b1;
          end else begin
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
